// File: rtl/fp_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_div_pkg
//  Description : Shared definitions for the fixed-point/exponent divider:
//                FSM state encoding, internal exponent width and the
//                representable exponent limits as functions of EW.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_div_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRENORM  = 3'd1,
    S_ALIGN    = 3'd2,
    S_DIV      = 3'd3,
    S_POSTNORM = 3'd4,
    S_DONE     = 3'd5
  } fsm_state_e;

  // Two guard bits above EW so E1-E2 plus normalisation steps do not wrap
  // before the range check.
  function automatic int fp_iew(input int ew);
    return ew + 2;
  endfunction

  function automatic int fp_emax(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic int fp_emin(input int ew);
    return -(1 << (ew - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/param_fp_divider_frac_divider.sv
`default_nettype none
// ============================================================================
//  Module      : frac_divider
//  Description : Unsigned restoring divider. Computes FW-1 fraction bits of
//                a_i / b_i (requires a_i < b_i) in exactly FW-1 cycles after
//                a one-cycle start_i pulse; done_o pulses for one cycle with
//                q_o valid from then until the next start.
//  Ports       : clk_i, rstn_i (async, active-low), start_i, a_i, b_i,
//                q_o (FW-1 bits), done_o
//  Revision    : 1.0 - initial release
// ============================================================================
module frac_divider #(
  parameter int FW = 8
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          start_i,
  input  logic [FW-1:0] a_i,
  input  logic [FW-1:0] b_i,
  output logic [FW-2:0] q_o,
  output logic          done_o
);

  localparam int c_cw = $clog2(FW);

  logic [FW:0]     rem_q;
  logic [FW-1:0]   b_q;
  logic [FW-2:0]   quo_q;
  logic [c_cw-1:0] cnt_q;
  logic            busy_q;
  logic            done_q;

  logic [FW:0]     rem_sh_d;
  logic            ge_d;
  logic [FW:0]     rem_d;

  // Remainder stays below b (<= 2^(FW-1)), so the shifted value fits FW+1 bits.
  assign rem_sh_d = {rem_q[FW-1:0], 1'b0};
  assign ge_d     = (rem_sh_d >= {1'b0, b_q});
  assign rem_d    = ge_d ? (rem_sh_d - {1'b0, b_q}) : rem_sh_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rem_q  <= '0;
      b_q    <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= {1'b0, a_i};
        b_q    <= b_i;
        quo_q  <= '0;
        cnt_q  <= c_cw'(FW - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_d;
        quo_q <= {quo_q[FW-3:0], ge_d};
        cnt_q <= cnt_q - c_cw'(1);
        if (cnt_q == c_cw'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign q_o    = quo_q;
  assign done_o = done_q;

endmodule
`default_nettype wire

// File: rtl/param_fp_divider.sv
`default_nettype none
// ============================================================================
//  Module      : param_fp_divider
//  Description : Floating-point style divider on (fraction, exponent) pairs.
//                Fractions are two's-complement in [-1,1), exponents are
//                two's-complement EW bits. Sequence: latch -> prenormalise ->
//                align (|F1| < |F2|) -> restoring divide -> postnormalise.
//  Ports       : clk_i, rstn_i (async, active-low), st_i, f1_i, f2_i, e1_i,
//                e2_i, fout_o, eout_o, done_o, v_o, u_o, dz_o
//  Config      : FPDIV_SAT_EN - saturate Fout/Eout on overflow/underflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_fp_divider
  import fp_div_pkg::*;
#(
  parameter int FW = 8,
  parameter int EW = 5
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          st_i,
  input  logic [FW-1:0] f1_i,
  input  logic [FW-1:0] f2_i,
  input  logic [EW-1:0] e1_i,
  input  logic [EW-1:0] e2_i,
  output logic [FW-1:0] fout_o,
  output logic [EW-1:0] eout_o,
  output logic          done_o,
  output logic          v_o,
  output logic          u_o,
  output logic          dz_o
);

  localparam int c_iew = fp_iew(EW);
  localparam logic signed [c_iew-1:0] c_emax = c_iew'(fp_emax(EW));
  localparam logic signed [c_iew-1:0] c_emin = c_iew'(fp_emin(EW));
  localparam logic signed [c_iew-1:0] c_eone = c_iew'(1);

  fsm_state_e              state_q;
  logic [FW-1:0]           f1_q, f2_q, fq_q;
  logic signed [c_iew-1:0] e1_q, e2_q, eq_q;
  logic                    s1_q, s2_q;
  logic [FW-1:0]           fout_q;
  logic [EW-1:0]           eout_q;
  logic                    done_q, v_q, u_q, dz_q;

  logic                    f1_norm_d, f2_norm_d, fq_norm_d;
  logic                    rsign_d;
  logic                    div_start_d, div_done_d;
  logic [FW-2:0]           div_q_d;
  logic [FW-1:0]           q_signed_d;
  logic                    ovf_d, unf_d;
  logic [FW-1:0]           fout_d;
  logic [EW-1:0]           eout_d;

  assign f1_norm_d = f1_q[FW-1] ^ f1_q[FW-2];
  assign f2_norm_d = f2_q[FW-1] ^ f2_q[FW-2];
  assign fq_norm_d = (fq_q[FW-1] ^ fq_q[FW-2]) || (fq_q == '0);
  // Left shifts during prenormalisation preserve the sign bit, so the input
  // signs remain valid after the fractions are replaced by magnitudes.
  assign rsign_d     = s1_q ^ s2_q;
  assign div_start_d = (state_q == S_ALIGN) && (f1_q < f2_q);
  assign q_signed_d  = rsign_d ? -{1'b0, div_q_d} : {1'b0, div_q_d};

  frac_divider #(.FW(FW)) u_frac_divider (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .start_i (div_start_d),
    .a_i     (f1_q),
    .b_i     (f2_q),
    .q_o     (div_q_d),
    .done_o  (div_done_d)
  );

  // Final result as it will be registered on entry to DONE.
  always_comb begin
    ovf_d  = (eq_q > c_emax);
    unf_d  = (eq_q < c_emin);
    fout_d = fq_q;
    eout_d = eq_q[EW-1:0];
`ifdef FPDIV_SAT_EN
    if (ovf_d) begin
      fout_d = rsign_d ? {1'b1, {(FW-1){1'b0}}} : {1'b0, {(FW-1){1'b1}}};
      eout_d = c_emax[EW-1:0];
    end else if (unf_d) begin
      fout_d = '0;
      eout_d = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      f1_q    <= '0;
      f2_q    <= '0;
      fq_q    <= '0;
      e1_q    <= '0;
      e2_q    <= '0;
      eq_q    <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      fout_q  <= '0;
      eout_q  <= '0;
      done_q  <= 1'b0;
      v_q     <= 1'b0;
      u_q     <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (st_i) begin
            f1_q    <= f1_i;
            f2_q    <= f2_i;
            e1_q    <= {{2{e1_i[EW-1]}}, e1_i};
            e2_q    <= {{2{e2_i[EW-1]}}, e2_i};
            s1_q    <= f1_i[FW-1];
            s2_q    <= f2_i[FW-1];
            state_q <= S_PRENORM;
          end
        end
        S_PRENORM: begin
          if (f2_q == '0) begin
            dz_q    <= 1'b1;
            v_q     <= 1'b1;
            done_q  <= 1'b1;
            fout_q  <= '0;
            eout_q  <= '0;
            state_q <= S_DONE;
          end else if (f1_q == '0) begin
            done_q  <= 1'b1;
            fout_q  <= '0;
            eout_q  <= '0;
            state_q <= S_DONE;
          end else if (!f1_norm_d || !f2_norm_d) begin
            if (!f1_norm_d) begin
              f1_q <= f1_q << 1;
              e1_q <= e1_q - c_eone;
            end
            if (!f2_norm_d) begin
              f2_q <= f2_q << 1;
              e2_q <= e2_q - c_eone;
            end
          end else begin
            // Continue with unsigned magnitudes; -1.0 becomes 2^(FW-1).
            f1_q    <= f1_q[FW-1] ? -f1_q : f1_q;
            f2_q    <= f2_q[FW-1] ? -f2_q : f2_q;
            state_q <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (f1_q >= f2_q) begin
            f1_q <= f1_q >> 1;
            e1_q <= e1_q + c_eone;
          end else begin
            eq_q    <= e1_q - e2_q;
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          if (div_done_d) begin
            fq_q    <= q_signed_d;
            state_q <= S_POSTNORM;
          end
        end
        S_POSTNORM: begin
          if (!fq_norm_d) begin
            fq_q <= fq_q << 1;
            eq_q <= eq_q - c_eone;
          end else begin
            done_q  <= 1'b1;
            v_q     <= ovf_d;
            u_q     <= unf_d;
            fout_q  <= fout_d;
            eout_q  <= eout_d;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // Holding St high keeps the result; a new start needs St low first.
          if (!st_i) begin
            done_q  <= 1'b0;
            v_q     <= 1'b0;
            u_q     <= 1'b0;
            dz_q    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fout_o = fout_q;
  assign eout_o = eout_q;
  assign done_o = done_q;
  assign v_o    = v_q;
  assign u_o    = u_q;
  assign dz_o   = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_param_fp_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_fp_divider
//  Description : Directed self-checking bench for param_fp_divider with
//                FW=8, EW=5. Expected values are hand-computed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_fp_divider;

  localparam int FW      = 8;
  localparam int EW      = 5;
  localparam int LAT_MAX = 4 * FW + 3;

  logic          clk;
  logic          rstn;
  logic          st;
  logic [FW-1:0] f1, f2;
  logic [EW-1:0] e1, e2;
  logic [FW-1:0] fout;
  logic [EW-1:0] eout;
  logic          done, v, u, dz;

  int vectors;
  int miscompares;

  param_fp_divider #(.FW(FW), .EW(EW)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .st_i   (st),
    .f1_i   (f1),
    .f2_i   (f2),
    .e1_i   (e1),
    .e2_i   (e2),
    .fout_o (fout),
    .eout_o (eout),
    .done_o (done),
    .v_o    (v),
    .u_o    (u),
    .dz_o   (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: start an operation, scramble the inputs once latched,
  // and return the cycle count until Done (-1 on timeout).
  task automatic start_op(input logic [FW-1:0] a, input logic [FW-1:0] b,
                          input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                          output int lat);
    @(negedge clk);
    f1 = a; f2 = b; e1 = ea; e2 = eb; st = 1'b1;
    lat = -1;
    for (int i = 1; i <= LAT_MAX; i++) begin
      @(negedge clk);
      if (i == 1) begin
        f1 = FW'($urandom); f2 = FW'($urandom);
        e1 = EW'($urandom); e2 = EW'($urandom);
      end
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_op();
    @(negedge clk);
    st = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; st = 1'b0; f1 = '0; f2 = '0; e1 = '0; e2 = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({fout, eout, done, v, u, dz} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got fout=%h eout=%h done=%b v=%b u=%b dz=%b, expected all 0",
               fout, eout, done, v, u, dz);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    start_op(8'b0100_0000, 8'b0110_0000, 5'd2, 5'd1, lat);
    vectors++;
    if (lat < 0) begin
      miscompares++;
      $display("FAIL basic_latency: got timeout, expected done within %0d", LAT_MAX);
    end
    vectors++;
    if (fout !== 8'b0101_0101) begin
      miscompares++;
      $display("FAIL basic_fout: got %b expected 01010101", fout);
    end
    vectors++;
    if (eout !== 5'd1 || {v, u, dz} !== 3'b000) begin
      miscompares++;
      $display("FAIL basic_eout_flags: got eout=%0d vudz=%b expected eout=1 vudz=000", eout, {v, u, dz});
    end
    release_op();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle_done: got %b expected 0", done);
    end
  endtask

  task automatic test_align();
    int lat;
    start_op(8'b0110_0000, 8'b0100_0000, 5'd2, 5'd1, lat);
    vectors++;
    if (lat < 0 || fout !== 8'b0110_0000 || eout !== 5'd2) begin
      miscompares++;
      $display("FAIL align: got lat=%0d fout=%b eout=%0d expected fout=01100000 eout=2", lat, fout, eout);
    end
    release_op();
  endtask

  task automatic test_negative_prenorm();
    int lat;
    start_op(8'b1100_0000, 8'b0110_0000, 5'd2, 5'd1, lat);
    vectors++;
    if (lat < 0 || fout !== 8'b1010_1011 || eout !== 5'd1) begin
      miscompares++;
      $display("FAIL negative: got lat=%0d fout=%b eout=%0d expected fout=10101011 eout=1", lat, fout, eout);
    end
    release_op();
    start_op(8'b0010_0000, 8'b0100_0000, 5'd0, 5'd0, lat);
    vectors++;
    if (lat < 0 || fout !== 8'b0100_0000 || eout !== 5'd0 || {v, u, dz} !== 3'b000) begin
      miscompares++;
      $display("FAIL prenorm: got lat=%0d fout=%b eout=%0d vudz=%b expected fout=01000000 eout=0 vudz=000",
               lat, fout, eout, {v, u, dz});
    end
    release_op();
  endtask

  task automatic test_zero_dividend();
    int lat;
    start_op(8'h00, 8'b0110_0000, 5'd3, 5'd1, lat);
    vectors++;
    if (lat < 0 || fout !== 8'h00 || eout !== 5'd0 || {v, u, dz} !== 3'b000) begin
      miscompares++;
      $display("FAIL zero_dividend: got lat=%0d fout=%b eout=%0d vudz=%b expected 0/0/000",
               lat, fout, eout, {v, u, dz});
    end
    release_op();
  endtask

  task automatic test_div_zero();
    int lat;
    start_op(8'b0100_0000, 8'h00, 5'd2, 5'd1, lat);
    vectors++;
    if (lat < 1 || lat > 2) begin
      miscompares++;
      $display("FAIL dz_latency: got %0d cycles expected 1..2", lat);
    end
    vectors++;
    if (dz !== 1'b1 || v !== 1'b1) begin
      miscompares++;
      $display("FAIL dz_flags: got dz=%b v=%b expected dz=1 v=1", dz, v);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (done !== 1'b1 || dz !== 1'b1) begin
      miscompares++;
      $display("FAIL dz_hold: got done=%b dz=%b expected 1 1", done, dz);
    end
    release_op();
    vectors++;
    if ({done, v, u, dz} !== 4'b0000) begin
      miscompares++;
      $display("FAIL dz_idle: got done,v,u,dz=%b expected 0000", {done, v, u, dz});
    end
  endtask

  task automatic test_overflow();
    int lat;
    start_op(8'b0100_0000, 8'b0110_0000, 5'd15, 5'b10000, lat);
    vectors++;
    if (lat < 0 || v !== 1'b1 || u !== 1'b0 || dz !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_flags: got lat=%0d v=%b u=%b dz=%b expected v=1 u=0 dz=0", lat, v, u, dz);
    end
`ifdef FPDIV_SAT_EN
    vectors++;
    if (fout !== 8'b0111_1111 || eout !== 5'd15) begin
      miscompares++;
      $display("FAIL ovf_result: got fout=%b eout=%b expected 01111111 01111", fout, eout);
    end
`else
    vectors++;
    if (fout !== 8'b0101_0101 || eout !== 5'b11111) begin
      miscompares++;
      $display("FAIL ovf_result: got fout=%b eout=%b expected 01010101 11111", fout, eout);
    end
`endif
    release_op();
  endtask

  task automatic test_underflow();
    int lat;
    // Eq = -16 - 15 = -31
    start_op(8'b0100_0000, 8'b0110_0000, 5'b10000, 5'd15, lat);
    vectors++;
    if (lat < 0 || u !== 1'b1 || v !== 1'b0) begin
      miscompares++;
      $display("FAIL unf_flags: got lat=%0d u=%b v=%b expected u=1 v=0", lat, u, v);
    end
`ifdef FPDIV_SAT_EN
    vectors++;
    if (fout !== 8'h00 || eout !== 5'd0) begin
      miscompares++;
      $display("FAIL unf_result: got fout=%b eout=%b expected 00000000 00000", fout, eout);
    end
`else
    vectors++;
    if (fout !== 8'b0101_0101 || eout !== 5'b00001) begin
      miscompares++;
      $display("FAIL unf_result: got fout=%b eout=%b expected 01010101 00001", fout, eout);
    end
`endif
    release_op();
  endtask

  task automatic test_reset_mid_div();
    int lat;
    @(negedge clk);
    f1 = 8'b0110_0000; f2 = 8'b0100_0000; e1 = 5'd7; e2 = 5'd1; st = 1'b1;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    vectors++;
    if ({fout, eout, done, v, u, dz} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_div: got fout=%h eout=%h done=%b v=%b u=%b dz=%b expected all 0",
               fout, eout, done, v, u, dz);
    end
    @(negedge clk);
    st = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    start_op(8'b0100_0000, 8'b0110_0000, 5'd2, 5'd1, lat);
    vectors++;
    if (lat < 0 || fout !== 8'b0101_0101 || eout !== 5'd1 || {v, u, dz} !== 3'b000) begin
      miscompares++;
      $display("FAIL after_reset: got lat=%0d fout=%b eout=%0d vudz=%b expected 01010101 1 000",
               lat, fout, eout, {v, u, dz});
    end
    release_op();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_align();
    test_negative_prenorm();
    test_zero_dividend();
    test_div_zero();
    test_overflow();
    test_underflow();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
